sub_8bit_serial: RTL and testbench



---
 rtl/sub_8bit_serial_pkg.sv | 12 +
 rtl/sub_8bit_serial_if.sv | 30 +++
 rtl/sub_8bit_serial_sub1.sv | 16 +
 rtl/sub_8bit_serial.sv | 112 +++++++++++
 tb/tb_sub_8bit_serial.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/sub_8bit_serial_pkg.sv
// Shared constants for the bit-serial subtractor: default operand width and
// the FSM state encodings (kept as plain 2-bit constants for legacy tools).
// Ports: none (package).
package sub_8bit_serial_pkg;

  localparam int SUB_WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/sub_8bit_serial_if.sv
// Start/done request bus for the bit-serial subtractor.
// master: drives start/A/B/Bin, receives busy/done/DIFF/Borrow/Overflow.
// slave : the subtractor side of the same bundle.
interface sub_8bit_serial_if
  import sub_8bit_serial_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] DIFF;
  logic             Borrow;
  logic             Overflow;

  modport master (
    output start, A, B, Bin,
    input  busy, done, DIFF, Borrow, Overflow
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, DIFF, Borrow, Overflow
  );

endinterface

// File: rtl/sub_8bit_serial_sub1.sv
// sub1: combinational one-bit full subtractor (a - b - bin), twin of add1.
// Latency: combinational. Backpressure: none.
// Ports: a, b, bin -> d (difference bit), bout (borrow out).
module sub_8bit_serial_sub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_8bit_serial.sv
// Bit-serial subtractor: DIFF = A - B - Bin, one bit per clock, LSB first.
// Latency: start at edge 0, done pulses the cycle after edge WIDTH; back-to-back via DONE->RUN.
// Backpressure: start is only sampled in IDLE/DONE; ignored while busy.
// Ports: clk, rst_n (synchronous, active-low), bus (sub_8bit_serial_if.slave).
// Optional: `define SUB_SIGNED_OVF_EN for signed overflow; otherwise Overflow is 0.
module sub_8bit_serial
  import sub_8bit_serial_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  sub_8bit_serial_if.slave bus
);

  localparam int              CW   = $clog2(WIDTH);
  localparam int              RW   = WIDTH - 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  // Only WIDTH-1 partial bits are stored; the final bit goes straight to DIFF.
  logic [RW-1:0]    res;
  logic             bw;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             d;
  logic             bo;
  logic             accept;
  logic             run;
  logic             last;

  assign run    = (state == ST_RUN);
  assign accept = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;
  assign last   = run && (cnt == LAST);

  sub_8bit_serial_sub1 u_sub1 (
    .a    (opa[0]),
    .b    (opb[0]),
    .bin  (bw),
    .d    (d),
    .bout (bo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      opa      <= '0;
      opb      <= '0;
      res      <= '0;
      bw       <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      state <= ST_RUN;
      cnt   <= '0;
      opa   <= bus.A;
      opb   <= bus.B;
      bw    <= bus.Bin;
    end else if (run) begin
      opa <= opa >> 1;
      opb <= opb >> 1;
      res <= RW'({d, res} >> 1);
      bw  <= bo;
      if (last) begin
        // Counter returns to zero through the transition, not by wrapping.
        state    <= ST_DONE;
        cnt      <= '0;
        diff_q   <= {d, res};
        borrow_q <= bo;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      // DONE without a new start, or an unused encoding.
      state <= ST_IDLE;
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  logic sa;
  logic sb;
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa    <= 1'b0;
      sb    <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      sa <= bus.A[WIDTH-1];
      sb <= bus.B[WIDTH-1];
    end else if (last) begin
      // d here is the result MSB being written into DIFF on this edge.
      ovf_q <= (sa != sb) && (d != sa);
    end
  end

  assign bus.Overflow = ovf_q;
`else
  assign bus.Overflow = 1'b0;
`endif

  assign bus.busy   = run;
  assign bus.done   = (state == ST_DONE);
  assign bus.DIFF   = diff_q;
  assign bus.Borrow = borrow_q;

endmodule

// File: tb/tb_sub_8bit_serial.sv
// Bench for sub_8bit_serial: directed vectors plus a reference-model sweep,
// checked by a scoreboard queue drained by an independent done monitor.
module tb_sub_8bit_serial;

  localparam int W = 8;
`ifdef SUB_SIGNED_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
    int         due;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;   // signed overflow when the feature is enabled
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   run_len = 0;
  exp_t q[$];
  exp_t mon_e;

  sub_8bit_serial_if #(.WIDTH(W)) bus ();

  sub_8bit_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  vec_t vecs[10] = '{
    '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0},
    '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0},
    '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1},
    '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},
    '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1},
    '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0},
    '{8'hAA, 8'h55, 1'b1, 8'h54, 1'b0, 1'b1},
    '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0},
    '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b1, 1'b0},
    '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.busy) run_len++;
    if (bus.done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        mon_e = q.pop_front();
        check("diff", 32'(bus.DIFF), 32'(mon_e.diff));
        check("borrow", 32'(bus.Borrow), 32'(mon_e.borrow));
        check("overflow", 32'(bus.Overflow), 32'(mon_e.ovf));
        check("done_cycle", 32'(cyc), 32'(mon_e.due));
        check("busy_len", 32'(run_len), 32'(W));
      end
    end
    if (!bus.busy) run_len = 0;
  end

  // Called at a negedge with the DUT idle or in DONE.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] ed, input logic eb, input logic eo);
    exp_t e;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    e.diff    = ed;
    e.borrow  = eb;
    e.ovf     = eo & OVF_EN;
    e.due     = cyc + 1 + W;
    q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    bus.Bin   = ~bin;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    exp_t e;
    logic [7:0] ra, rb, rd;
    logic       rbin, rbo, rov;

    bus.start = 1'b0;
    bus.A     = 8'h00;
    bus.B     = 8'h00;
    bus.Bin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.DIFF), 32'd0);
    check("rst_borrow", 32'(bus.Borrow), 32'd0);
    check("rst_overflow", 32'(bus.Overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].borrow, vecs[i].ovf);
      drain();
    end

    // Back-to-back: start held high through DONE, second op accepted from DONE.
    bus.start = 1'b1;
    bus.A = 8'h00; bus.B = 8'h00; bus.Bin = 1'b1;
    e.diff = 8'hFF; e.borrow = 1'b1; e.ovf = 1'b0; e.due = cyc + 1 + W;
    q.push_back(e);
    e.diff = 8'h0F; e.borrow = 1'b0; e.ovf = 1'b0; e.due = e.due + W + 1;
    q.push_back(e);
    @(negedge clk);
    bus.A = 8'h10; bus.B = 8'h01; bus.Bin = 1'b0;
    repeat (W + 1) @(negedge clk);
    bus.start = 1'b0;
    bus.A = 8'hC3; bus.B = 8'h3C;
    drain();

    // Start while busy is ignored; its operands never reach DIFF.
    issue(8'h3C, 8'h0F, 1'b0, 8'h2D, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.A = 8'hEE; bus.B = 8'h11; bus.Bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (12) @(negedge clk);
    check("ignored_start_diff", 32'(bus.DIFF), 32'h2D);
    check("ignored_start_busy", 32'(bus.busy), 32'd0);

    // Reset in cycle 4 of RUN, with start high on the same edge.
    bus.start = 1'b1; bus.A = 8'h55; bus.B = 8'h22; bus.Bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    bus.start = 1'b1; bus.A = 8'h77; bus.B = 8'h01;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_diff", 32'(bus.DIFF), 32'd0);
    check("abort_borrow", 32'(bus.Borrow), 32'd0);
    check("abort_overflow", 32'(bus.Overflow), 32'd0);
    rst_n = 1'b1;
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_quiet_busy", 32'(bus.busy), 32'd0);
    check("abort_quiet_diff", 32'(bus.DIFF), 32'd0);

    // Sweep against (A - B - Bin) mod 256 with unsigned/signed borrow rules.
    for (int n = 0; n < 500; n++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      rd   = ra - rb - {7'd0, rbin};
      rbo  = ({1'b0, ra} < ({1'b0, rb} + {8'd0, rbin}));
      rov  = (ra[7] != rb[7]) && (rd[7] != ra[7]);
      issue(ra, rb, rbin, rd, rbo, rov);
      drain();
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
